// File: rtl/data_bus_bridge.sv
// rtl/data_bus_bridge.sv - MEM-stage to valid/ready data bus bridge with wait states, error and timeout
module data_bus_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] mem_addr,
  input  logic        mem_cmd,
  input  logic [31:0] mem_write_data,
  input  logic [3:0]  mem_write_mask,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        fault,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             timed_out;

  assign stall     = req_valid && (state != DONE);
  assign timed_out = (TIMEOUT != 0) && (count == LAST_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      fault     <= 1'b0;
      load_data <= 32'h0;
      bus_valid <= 1'b0;
      bus_addr  <= 32'h0;
      bus_we    <= 1'b0;
      bus_wdata <= 32'h0;
      bus_wstrb <= 4'h0;
    end else begin
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            // A store with no byte enables has nothing to do on the bus.
            if (mem_cmd && (mem_write_mask == 4'h0)) begin
              state <= DONE;
            end else begin
              bus_valid <= 1'b1;
              bus_addr  <= mem_addr & 32'hFFFF_FFFC;
              bus_we    <= mem_cmd;
              bus_wdata <= mem_cmd ? mem_write_data : 32'h0;
              bus_wstrb <= mem_cmd ? mem_write_mask : 4'h0;
              count     <= '0;
              state     <= BUS;
            end
          end
        end
        BUS: begin
          // Error wins over ready; a failed read returns zero rather than stale data.
          if (bus_err || (!bus_ready && timed_out)) begin
            bus_valid <= 1'b0;
            fault     <= 1'b1;
            if (!bus_we) load_data <= 32'h0;
            state     <= DONE;
          end else if (bus_ready) begin
            bus_valid <= 1'b0;
            if (!bus_we) load_data <= bus_rdata;
            state     <= DONE;
          end else if (count != {CNT_W{1'b1}}) begin
            count <= count + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// tb/tb_data_bus_bridge.sv - randomized self-checking bench for data_bus_bridge
module tb_data_bus_bridge;

  localparam int TMO = 4;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] mem_addr;
  logic        mem_cmd;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_mask;
  logic [31:0] load_data;
  logic        stall;
  logic        fault;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_load = 32'h0;

  data_bus_bridge #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .mem_addr(mem_addr),
    .mem_cmd(mem_cmd), .mem_write_data(mem_write_data), .mem_write_mask(mem_write_mask),
    .load_data(load_data), .stall(stall), .fault(fault), .bus_valid(bus_valid),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One access; slave raises ready on BUS cycle rdly and err on BUS cycle edly (0-based).
  task automatic run_txn(input logic [31:0] addr, input logic cmd, input logic [31:0] data,
                         input logic [3:0] mask, input int rdly, input int edly,
                         input logic [31:0] rdata);
    int bv, stalls, k_end;
    logic exp_fault, skip;
    skip = cmd && (mask == 4'h0);
    k_end = TMO - 1;
    if (rdly < k_end) k_end = rdly;
    if (edly < k_end) k_end = edly;
    exp_fault = !skip && ((edly == k_end) || (rdly != k_end));
    if (!skip && !cmd) exp_load = exp_fault ? 32'h0 : rdata;

    @(negedge clk);
    req_valid = 1'b1; mem_addr = addr; mem_cmd = cmd;
    mem_write_data = data; mem_write_mask = mask;
    bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    bv = 0; stalls = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      bus_ready = 1'b0; bus_err = 1'b0;
      if (bus_valid) begin
        check("bus_addr", bus_addr, {addr[31:2], 2'b00});
        check("bus_we", {31'h0, bus_we}, {31'h0, cmd});
        check("bus_wdata", bus_wdata, cmd ? data : 32'h0);
        check("bus_wstrb", {28'h0, bus_wstrb}, cmd ? {28'h0, mask} : 32'h0);
        bus_ready = (bv == rdly);
        bus_err   = (bv == edly);
        bus_rdata = (bv == rdly) ? rdata : $urandom;
        bv++;
      end
      if (stall) begin
        stalls++;
        check("fault_idle", {31'h0, fault}, 32'h0);
      end else begin
        check("fault", {31'h0, fault}, {31'h0, exp_fault});
        check("load_data", load_data, exp_load);
        check("bv_cycles", bv, skip ? 0 : k_end + 1);
        check("stall_cycles", stalls, skip ? 1 : k_end + 2);
        req_valid = 1'b0; bus_ready = 1'b0; bus_err = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("txn_timeout", 32'h1, 32'h0);
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; mem_addr = 32'h0; mem_cmd = 1'b0;
    mem_write_data = 32'h0; mem_write_mask = 4'h0;
    bus_ready = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'h0, bus_valid}, 32'h0);
    check("rst_load", load_data, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    reset = 1'b0;

    run_txn(32'h0000_1003, 1'b0, 32'h0, 4'h0, 0, NEVER, 32'hDEADBEEF);
    run_txn(32'h0000_0020, 1'b1, 32'h00AB0000, 4'b0100, 3, NEVER, 32'h0);
    run_txn(32'h0000_0040, 1'b1, 32'h11111111, 4'b0000, 0, NEVER, 32'h0);
    run_txn(32'h0000_0044, 1'b0, 32'h0, 4'h0, NEVER, NEVER, 32'h0);
    run_txn(32'h0000_0048, 1'b0, 32'h0, 4'h0, 1, NEVER, 32'hCAFEF00D);
    run_txn(32'h0000_004C, 1'b0, 32'h0, 4'h0, 0, 0, 32'h12345678);

    // Reset during the second BUS cycle abandons the transfer.
    @(negedge clk);
    req_valid = 1'b1; mem_addr = 32'h0000_0080; mem_cmd = 1'b0;
    mem_write_data = 32'h0; mem_write_mask = 4'h0;
    bus_ready = 1'b0; bus_err = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_valid", {31'h0, bus_valid}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    check("post_rst_valid", {31'h0, bus_valid}, 32'h0);
    check("post_rst_addr", bus_addr, 32'h0);
    check("post_rst_stall", {31'h0, stall}, 32'h0);
    exp_load = 32'h0;
    run_txn(32'h0000_0084, 1'b0, 32'h0, 4'h0, 2, NEVER, 32'h0BADF00D);

    for (int i = 0; i < 40; i++) begin
      logic c;
      logic [3:0] m;
      int rd, ed;
      c  = $urandom_range(0, 1);
      m  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      rd = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, 4);
      ed = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4) : NEVER;
      run_txn($urandom, c, $urandom, m, rd, ed, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_bus_bridge.md
Name: data_bus_bridge

Overview:
Sits directly downstream of the data memory controller, between the MEM stage and the external data bus/SRAM. Turns one word-aligned access request (address, write data, byte mask, read/write command) into a valid/ready bus transaction with arbitrary wait states. Stalls the pipeline until the access completes and returns the raw 32-bit read word to the controller's load-alignment logic. Reports bus errors and timeouts.

Parameters:
TIMEOUT, 255, maximum number of cycles to wait for bus_ready in BUS; 0 disables the timeout.
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  MEM stage holds a load/store; held stable while stall=1
mem_addr  input  32  word-aligned address; bits [1:0] ignored and driven 0 on the bus
mem_cmd  input  1  1=write, 0=read
mem_write_data  input  32  lane-positioned store data
mem_write_mask  input  4  byte enables for writes
load_data  output  32  raw read word; valid in DONE, held until the next read completes
stall  output  1  freeze pipeline (combinational)
fault  output  1  one-cycle pulse in DONE when the access ended by bus_err or timeout
bus_valid  output  1  request strobe
bus_addr  output  32  registered address
bus_we  output  1  registered write enable
bus_wdata  output  32  registered write data
bus_wstrb  output  4  registered byte strobes
bus_ready  input  1  slave accepted/completed the transfer this cycle
bus_rdata  input  32  read data; sampled when bus_valid and bus_ready are both 1
bus_err  input  1  slave error; sampled when bus_valid=1

Behaviour:
- States: IDLE, BUS, DONE (2-bit encoding).
- Reset: state=IDLE; bus_valid=0; bus_addr, bus_wdata, load_data=0; bus_we=0; bus_wstrb=0; fault=0; counter=0. A reset during BUS drops bus_valid at that same edge and discards the transaction. The slave must tolerate an abandoned request.
- stall = req_valid && (state != DONE).
- IDLE:
  - If req_valid=1 and mem_cmd=1 and mem_write_mask=0000: go to DONE with no bus transaction.
  - Else if req_valid=1: register addr {mem_addr[31:2],2'b00}, cmd, data and mask; set bus_valid=1; clear the counter; go to BUS. For reads, bus_wstrb=0000 and bus_wdata=0.
  - Else stay in IDLE.
- BUS:
  - bus_valid=1. Bus outputs are stable until the transaction completes.
  - If bus_err=1: go to DONE with fault=1. Error takes priority over bus_ready in the same cycle.
  - Else if bus_ready=1: for a read, load_data<=bus_rdata. Go to DONE with fault=0.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: go to DONE with fault=1.
  - Otherwise counter+1. The counter saturates and never wraps.
  - In all three exits, bus_valid drops at the transition edge.
- DONE: lasts exactly one cycle. stall=0, so the pipeline advances. Always go to IDLE. A fault on a read leaves load_data at 32'h0.
- Latency: zero-wait-state slave gives 3 cycles (IDLE, BUS, DONE), with stall high for 2 cycles. Each extra wait state adds 1 cycle.
- Back-to-back: a new request presented in the cycle after DONE starts from IDLE with no extra bubble.
- If req_valid drops while in BUS (pipeline flush), the transaction still completes on the bus, but the result is discarded by the stage. The FSM is unaffected.
- bus_ready or bus_err while bus_valid=0 is ignored.

Test Plan:
1. Read addr 0x0000_1003, slave ready with 0 waits, rdata=0xDEADBEEF -> bus_addr=0x0000_1000, bus_we=0, wstrb=0000; stall high 2 cycles; load_data=0xDEADBEEF in DONE; fault=0.
2. Write addr 0x20, data 0x00AB0000, mask 0100, slave 3 wait states -> bus_valid high 4 cycles with stable outputs; wstrb=0100, wdata=0x00AB0000; stall high 5 cycles.
3. Write with mask 0000 -> no bus_valid ever; IDLE->DONE; stall high 1 cycle.
4. TIMEOUT=4, read, slave never ready -> bus_valid high exactly 4 cycles; fault pulses 1 cycle; load_data=0x0; next request proceeds normally.
5. bus_err and bus_ready both 1 in the first BUS cycle, rdata=0x12345678 -> fault=1; load_data not updated from rdata.
6. Reset asserted in the 2nd BUS cycle -> next edge: bus_valid=0, state IDLE, all outputs at reset values; a new read after reset completes normally.
